// File: rtl/sva_pkg.sv
// Shared types and constants for the sampled-value monitor.
package sva_pkg;

   typedef enum logic [1:0] {
      MODE_ROSE,
      MODE_FELL,
      MODE_STABLE,
      MODE_CHANGED
   } sva_mode_e;

   localparam int FAIL_CNT_W = 16;

endpackage

// File: rtl/past_history.sv
// Per-channel enabled history shift register; past is the value DEPTH samples ago.
module past_history #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] val,
   output logic [WIDTH-1:0] past
);

   logic [WIDTH-1:0] hist [DEPTH];

   // Zeroed history matches the $past default before warm-up completes.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < int'(DEPTH); k++) begin
            hist[k] <= '0;
         end
      end else if (en) begin
         hist[0] <= val;
         for (int k = 1; k < int'(DEPTH); k++) begin
            hist[k] <= hist[k-1];
         end
      end
   end

   assign past = hist[DEPTH-1];

endmodule

// File: rtl/sampled_edge_checker.sv
// Multi-channel sampled-value flags plus "ante |-> ##DELAY fn(val)" obligation checking.
module sampled_edge_checker
   import sva_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 1,
   parameter int unsigned DELAY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [WIDTH-1:0]      val,
   input  logic [WIDTH-1:0]      ante,
   input  logic [WIDTH-1:0][1:0] mode,
   output logic [WIDTH-1:0]      rose,
   output logic [WIDTH-1:0]      fell,
   output logic [WIDTH-1:0]      stable,
   output logic [WIDTH-1:0]      changed,
   output logic                  hist_valid,
   output logic [WIDTH-1:0]      pass,
   output logic [WIDTH-1:0]      fail,
   output logic [FAIL_CNT_W-1:0] fail_cnt
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
      $error("sampled_edge_checker: WIDTH must be 1..64");
   end
   if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
      $error("sampled_edge_checker: DEPTH must be 1..16");
   end
   if (DELAY < 1 || DELAY > 16) begin : g_bad_delay
      $error("sampled_edge_checker: DELAY must be 1..16");
   end

   logic [WIDTH-1:0] past;
   logic [WIDTH-1:0] sel;
   logic [WIDTH-1:0] resolve;
   logic [WIDTH-1:0] pass_nxt;
   logic [WIDTH-1:0] fail_nxt;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] pipe [DELAY];

   past_history #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_hist (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .val  (val),
      .past (past)
   );

   // Flags and resolution are evaluated against the current sample; mode is read here, at resolution.
   always_comb begin
      rose     = val & ~past;
      fell     = ~val & past;
      stable   = ~(val ^ past);
      changed  = val ^ past;
      sel      = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         case (sva_mode_e'(mode[i]))
            MODE_ROSE:    sel[i] = rose[i];
            MODE_FELL:    sel[i] = fell[i];
            MODE_STABLE:  sel[i] = stable[i];
            MODE_CHANGED: sel[i] = changed[i];
            default:      sel[i] = 1'b0;
         endcase
      end
      resolve  = en ? pipe[DELAY-1] : '0;
      pass_nxt = resolve & sel;
      fail_nxt = resolve & ~sel;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         hist_valid <= 1'b0;
         pass       <= '0;
         fail       <= '0;
         fail_cnt   <= '0;
         for (int k = 0; k < int'(DELAY); k++) begin
            pipe[k] <= '0;
         end
      end else begin
         pass <= pass_nxt;
         fail <= fail_nxt;
         if (en) begin
            // Warm-up counter stops once DEPTH samples are held.
            if (!hist_valid) begin
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(DEPTH - 1)) begin
                  hist_valid <= 1'b1;
               end
            end
            pipe[0] <= hist_valid ? ante : '0;
            for (int k = 1; k < int'(DELAY); k++) begin
               pipe[k] <= pipe[k-1];
            end
            if ((|fail_nxt) && (fail_cnt != '1)) begin
               fail_cnt <= fail_cnt + FAIL_CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_sampled_edge_checker.sv
// Directed and random checks of sampled_edge_checker (WIDTH=8, DEPTH=3, DELAY=4) against a scoreboard model.
module tb_sampled_edge_checker;

   localparam int W  = 8;
   localparam int DP = 3;
   localparam int DL = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic [W-1:0]     val;
   logic [W-1:0]     ante;
   logic [W-1:0][1:0] mode;
   logic [W-1:0]     rose, fell, stable, changed;
   logic             hist_valid;
   logic [W-1:0]     pass, fail;
   logic [15:0]      fail_cnt;

   sampled_edge_checker #(.WIDTH(W), .DEPTH(DP), .DELAY(DL)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .val        (val),
      .ante       (ante),
      .mode       (mode),
      .rose       (rose),
      .fell       (fell),
      .stable     (stable),
      .changed    (changed),
      .hist_valid (hist_valid),
      .pass       (pass),
      .fail       (fail),
      .fail_cnt   (fail_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] p;
      logic [W-1:0] f;
      logic [15:0]  fc;
      logic         hv;
   } exp_t;

   exp_t sb[$];

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [W-1:0] mh [DP];
   logic [W-1:0] mp [DL];
   int           mcnt;
   logic [15:0]  mfc;
   logic         mknown = 1'b0;
   int           pass0_seen;
   int           pulse_seen;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic r, input logic e, input logic [W-1:0] v,
                       input logic [W-1:0] a, input logic [2*W-1:0] m);
      logic [W-1:0] past, er, ef, es, ec, sel, res;
      exp_t x, got;
      rst = r; en = e; val = v; ante = a; mode = m;
      #1;
      past = mh[DP-1];
      er = v & ~past;
      ef = ~v & past;
      es = ~(v ^ past);
      ec = v ^ past;
      if (mknown) begin
         chk("rose",    64'(rose),    64'(er));
         chk("fell",    64'(fell),    64'(ef));
         chk("stable",  64'(stable),  64'(es));
         chk("changed", 64'(changed), 64'(ec));
      end
      for (int i = 0; i < W; i++) begin
         case (m[2*i +: 2])
            2'd0:    sel[i] = er[i];
            2'd1:    sel[i] = ef[i];
            2'd2:    sel[i] = es[i];
            default: sel[i] = ec[i];
         endcase
      end
      if (r) begin
         for (int k = 0; k < DP; k++) mh[k] = '0;
         for (int k = 0; k < DL; k++) mp[k] = '0;
         mcnt = 0;
         mfc = '0;
         x = '0;
         mknown = 1'b1;
      end else begin
         res = e ? mp[DL-1] : '0;
         x.p = res & sel;
         x.f = res & ~sel;
         if (e && (|x.f) && mfc != 16'hFFFF) mfc = mfc + 16'd1;
         x.fc = mfc;
         if (e) begin
            for (int k = DL-1; k > 0; k--) mp[k] = mp[k-1];
            mp[0] = (mcnt == DP) ? a : '0;
            for (int k = DP-1; k > 0; k--) mh[k] = mh[k-1];
            mh[0] = v;
            if (mcnt < DP) mcnt++;
         end
         x.hv = (mcnt == DP);
      end
      sb.push_back(x);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      chk("pass",       64'(pass),       64'(got.p));
      chk("fail",       64'(fail),       64'(got.f));
      chk("fail_cnt",   64'(fail_cnt),   64'(got.fc));
      chk("hist_valid", 64'(hist_valid), 64'(got.hv));
      if (pass[0]) pass0_seen++;
      if ((|pass) || (|fail)) pulse_seen++;
      @(negedge clk);
   endtask

   task automatic reset2();
      step(1'b1, 1'b0, '0, '0, '0);
      step(1'b1, 1'b1, 8'hFF, 8'hFF, '0);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; val = '0; ante = '0; mode = '0;
      @(negedge clk);

      // Reset state
      reset2();
      chk("rst_pass", 64'(pass), 64'(0));
      chk("rst_fail_cnt", 64'(fail_cnt), 64'(0));
      chk("rst_hv", 64'(hist_valid), 64'(0));

      // Warm-up: 1,0,0,1 on channel 0
      step(1'b0, 1'b1, 8'h01, '0, '0);
      step(1'b0, 1'b1, 8'h00, '0, '0);
      chk("hv_after2", 64'(hist_valid), 64'(0));
      step(1'b0, 1'b1, 8'h00, '0, '0);
      chk("hv_after3", 64'(hist_valid), 64'(1));
      rst = 1'b0; en = 1'b1; val = 8'h01; #1;
      chk("rose_depth3", 64'(rose[0]), 64'(0));
      step(1'b0, 1'b1, 8'h01, '0, '0);

      // Toggling val with ROSE; ante on rising samples passes, on falling samples fails
      reset2();
      for (int t = 0; t < 20; t++)
         step(1'b0, 1'b1, 8'(t & 1), (t >= 4 && (t & 1) == 1) ? 8'h01 : 8'h00, '0);
      chk("toggle_no_fail", 64'(fail_cnt), 64'(0));
      for (int t = 0; t < 12; t++)
         step(1'b0, 1'b1, 8'(t & 1), ((t & 1) == 0) ? 8'h01 : 8'h00, '0);

      // DELAY: two consecutive antecedents, STABLE, with a 2-cycle en gap
      reset2();
      pass0_seen = 0;
      for (int t = 0; t < 3; t++) step(1'b0, 1'b1, 8'hFF, '0, 16'hAAAA);
      step(1'b0, 1'b1, 8'hFF, 8'h01, 16'hAAAA);
      step(1'b0, 1'b1, 8'hFF, 8'h01, 16'hAAAA);
      step(1'b0, 1'b0, 8'hFF, '0, 16'hAAAA);
      step(1'b0, 1'b0, 8'hFF, '0, 16'hAAAA);
      for (int t = 0; t < 8; t++) step(1'b0, 1'b1, 8'hFF, '0, 16'hAAAA);
      chk("delay_two_passes", 64'(pass0_seen), 64'(2));

      // Per-channel modes 0..3, val 0x00 -> 0xFF
      reset2();
      for (int t = 0; t < 3; t++) step(1'b0, 1'b1, 8'h00, '0, 16'hE4E4);
      step(1'b0, 1'b1, 8'h00, 8'hFF, 16'hE4E4);
      for (int t = 0; t < 3; t++) step(1'b0, 1'b1, 8'h00, '0, 16'hE4E4);
      step(1'b0, 1'b1, 8'hFF, '0, 16'hE4E4);
      chk("mix_pass", 64'(pass), 64'(8'h99));
      chk("mix_fail", 64'(fail), 64'(8'h66));
      chk("mix_fail_cnt", 64'(fail_cnt), 64'(1));

      // Reset while three obligations are pending
      reset2();
      for (int t = 0; t < 3; t++) step(1'b0, 1'b1, 8'h00, '0, '0);
      for (int t = 0; t < 3; t++) step(1'b0, 1'b1, 8'h00, 8'hFF, '0);
      step(1'b1, 1'b1, 8'h00, '0, '0);
      chk("midrst_hv", 64'(hist_valid), 64'(0));
      pulse_seen = 0;
      for (int t = 0; t < DL + 3; t++) step(1'b0, 1'b1, 8'h00, '0, '0);
      chk("midrst_no_pulse", 64'(pulse_seen), 64'(0));
      chk("midrst_fail_cnt", 64'(fail_cnt), 64'(0));

      // Random traffic
      for (int t = 0; t < 300; t++)
         step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
              8'($urandom), 8'($urandom), 16'($urandom));

      // Saturation
      reset2();
      for (int t = 0; t < 70000; t++) step(1'b0, 1'b1, 8'h00, 8'h01, '0);
      chk("fail_cnt_sat", 64'(fail_cnt), 64'(16'hFFFF));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
